button_press_detect: RTL and testbench

BUTTON_PRESS_DETECT -- requirements
Module: button_press_detect

---
 rtl/button_press_detect.sv | 139 +++++++++++++
 tb/tb_button_press_detect.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/button_press_detect.sv
// Debounced pushbutton with short-press, long-press and auto-repeat strobes.
// A 2-flop synchronizer feeds a five-state FSM whose outputs are all registered.
module button_press_detect #(
  parameter int DEB_CYCLES    = 120000,
  parameter int LONG_CYCLES   = 12000000,
  parameter int REPEAT_CYCLES = 3000000
) (
  input  logic clk,
  input  logic rstn,
  input  logic sw_in,
  output logic pressed,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam int DEB_W  = $clog2(DEB_CYCLES);
  localparam int HOLD_W = $clog2(LONG_CYCLES);
  localparam int REP_W  = $clog2(REPEAT_CYCLES);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    LONG,
    DEB_REL
  } state_t;

  state_t              state;
  logic                sync_q1;
  logic                sync;
  logic                was_long;
  logic [DEB_W-1:0]    deb_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [REP_W-1:0]    rep_cnt;

  // NOTE: non-blocking assignments keep the two flops a true shift register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_q1 <= 1'b0;
      sync    <= 1'b0;
    end else begin
      sync_q1 <= sw_in;
      sync    <= sync_q1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      was_long     <= 1'b0;
      deb_cnt      <= '0;
      hold_cnt     <= '0;
      rep_cnt      <= '0;
      pressed      <= 1'b0;
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
      held         <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle so each is exactly one cycle wide.
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;

      unique case (state)
        IDLE: begin
          if (sync) begin
            state   <= DEB_PRESS;
            deb_cnt <= '0;
          end
        end

        DEB_PRESS: begin
          if (!sync) begin
            state <= IDLE;
          end else if (deb_cnt == DEB_LAST) begin
            state    <= PRESSED;
            pressed  <= 1'b1;
            hold_cnt <= '0;
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end

        PRESSED: begin
          // Release wins over a coincident terminal count.
          if (!sync) begin
            state    <= DEB_REL;
            was_long <= 1'b0;
            deb_cnt  <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state      <= LONG;
            long_pulse <= 1'b1;
            held       <= 1'b1;
            rep_cnt    <= '0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        LONG: begin
          if (!sync) begin
            state    <= DEB_REL;
            was_long <= 1'b1;
            deb_cnt  <= '0;
          end else if (rep_cnt == REP_LAST) begin
            repeat_pulse <= 1'b1;
            rep_cnt      <= '0;
          end else begin
            rep_cnt <= rep_cnt + REP_W'(1);
          end
        end

        DEB_REL: begin
          // Hold and repeat counters stay frozen so a bounce resumes where it left off.
          if (sync) begin
            state <= was_long ? LONG : PRESSED;
          end else if (deb_cnt == DEB_LAST) begin
            state       <= IDLE;
            pressed     <= 1'b0;
            held        <= 1'b0;
            short_pulse <= ~was_long;
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_press_detect.sv
// Scoreboard bench for button_press_detect: directed scenarios plus random
// press/bounce/reset traffic, compared every cycle against a behavioural model.
module tb_button_press_detect;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int REP  = 5;

  typedef struct packed {
    logic pressed;
    logic short_p;
    logic long_p;
    logic rep_p;
    logic held;
  } exp_t;

  logic clk;
  logic rstn;
  logic sw_in;
  logic pressed;
  logic short_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic held;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  exp_t exp_q[$];

  // Behavioural model: debounced level, run of disagreeing samples, and the
  // number of stable pressed cycles seen during the current press.
  logic m_s1, m_s2;
  logic m_lvl;
  int   m_dis;
  int   m_stable;

  button_press_detect #(
    .DEB_CYCLES   (DEB),
    .LONG_CYCLES  (LONG),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .sw_in       (sw_in),
    .pressed     (pressed),
    .short_pulse (short_pulse),
    .long_pulse  (long_pulse),
    .repeat_pulse(repeat_pulse),
    .held        (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req)
      $display("FAIL %s: got %b, expected %b", name, act[4:0], req[4:0]);
    else
      n_pass++;
  endtask

  function automatic exp_t model_edge(input logic sw, input logic rst);
    exp_t e;
    logic s;
    e = '0;
    if (!rst) begin
      m_s1     = 1'b0;
      m_s2     = 1'b0;
      m_lvl    = 1'b0;
      m_dis    = 0;
      m_stable = 0;
    end else begin
      s = m_s2;
      if (s != m_lvl) begin
        m_dis++;
        // A change is accepted once it has disagreed for DEB+1 sampled edges.
        if (m_dis == DEB + 1) begin
          if (m_lvl && m_stable < LONG) e.short_p = 1'b1;
          m_lvl    = ~m_lvl;
          m_dis    = 0;
          m_stable = 0;
        end
      end else begin
        if (m_lvl && m_dis == 0) begin
          m_stable++;
          if (m_stable == LONG) e.long_p = 1'b1;
          else if (m_stable > LONG && (m_stable - LONG) % REP == 0) e.rep_p = 1'b1;
        end
        m_dis = 0;
      end
      m_s2 = m_s1;
      m_s1 = sw;
    end
    e.pressed = m_lvl;
    e.held    = m_lvl && (m_stable >= LONG);
    return e;
  endfunction

  task automatic step(input logic sw, input logic rst);
    @(negedge clk);
    sw_in = sw;
    rstn  = rst;
    exp_q.push_back(model_edge(sw, rst));
  endtask

  task automatic hold(input logic sw, input int n);
    for (int i = 0; i < n; i++) step(sw, 1'b1);
  endtask

  // Monitor: one expected entry per clock edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("outputs@%0d", cyc),
              {27'd0, pressed, short_pulse, long_pulse, repeat_pulse, held},
              {27'd0, e});
      end
    end
  end

  initial begin
    logic sw;
    int   len;
    rstn  = 1'b0;
    sw_in = 1'b0;
    m_s1 = 1'b0; m_s2 = 1'b0; m_lvl = 1'b0; m_dis = 0; m_stable = 0;

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    hold(1'b0, 5);

    // Short press.
    hold(1'b1, 10);  hold(1'b0, 12);
    // Glitch shorter than the debounce window.
    hold(1'b1, 2);   hold(1'b0, 10);
    // Long press with auto-repeat.
    hold(1'b1, 40);  hold(1'b0, 12);
    // Release bounce while pressed delays the long press.
    hold(1'b1, 12);  hold(1'b0, 2);  hold(1'b1, 30);  hold(1'b0, 12);
    // Release lands exactly on the hold terminal-count cycle.
    hold(1'b1, 24);  hold(1'b0, 12);
    // Reset during a long press, button still held.
    hold(1'b1, 30);  step(1'b1, 1'b0);  hold(1'b1, 12);  hold(1'b0, 12);

    for (int r = 0; r < 120; r++) begin
      sw  = logic'($urandom_range(0, 1));
      len = $urandom_range(1, 35);
      if ($urandom_range(0, 39) == 0) step(sw, 1'b0);
      hold(sw, len);
    end
    hold(1'b0, 10);

    @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
